// File: rtl/mips_trace_encoder.sv
// Commit-trace encoder: packs decode, store and writeback events into a
// record FIFO drained over valid/ready, with lossy but counted overflow.
module mips_trace_encoder #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [10:0]                dec_pc,
    input  logic [31:0]                dec_instr,
    input  logic                       mem_we,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic                       reg_we,
    input  logic [4:0]                 reg_waddr,
    input  logic [31:0]                reg_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_type,
    output logic [31:0]                out_addr,
    output logic [31:0]                out_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] T_DEC = 2'd0;
    localparam logic [1:0] T_MEM = 2'd1;
    localparam logic [1:0] T_REG = 2'd2;
    localparam logic [1:0] T_OVF = 2'd3;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    typedef struct packed {
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_rec_t;

    trace_rec_t          mem_q [DEPTH];
    trace_rec_t          mem_d [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [CNT_W-1:0]    drop_q, drop_d;

    logic                reg_ok;
    logic [2:0]          k;
    logic                ovf_pend;
    logic [LW-1:0]       need;
    logic [LW-1:0]       free;
    logic                accept;
    logic                pop;
    logic [AW-1:0]       widx;
    logic [LW-1:0]       wr_cnt;
    logic [CNT_W:0]      drop_sum;
    trace_rec_t          head;

    // Slot accounting uses start-of-cycle occupancy; a same-cycle pop is not credited.
    always_comb begin
        reg_ok   = reg_we && (reg_waddr != 5'd0);
        k        = en ? (3'd1 + {2'b00, mem_we} + {2'b00, reg_ok}) : 3'd0;
        ovf_pend = (drop_q != '0);
        need     = LW'(k) + LW'(ovf_pend);
        free     = LVL_MAX - level_q;
        accept   = (need != '0) && (free >= need);
        pop      = out_valid && out_ready;
        drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(k);
    end

    always_comb begin
        mem_d  = mem_q;
        widx   = wr_ptr_q;
        wr_cnt = '0;
        drop_d = drop_q;
        if (accept) begin
            if (ovf_pend) begin
                mem_d[widx] = '{typ: T_OVF, addr: 32'd0, data: 32'(drop_q)};
                widx        = widx + PTR_ONE;
            end
            if (en) begin
                mem_d[widx] = '{typ: T_DEC, addr: {21'd0, dec_pc}, data: dec_instr};
                widx        = widx + PTR_ONE;
            end
            if (en && mem_we) begin
                mem_d[widx] = '{typ: T_MEM, addr: mem_addr, data: mem_wdata};
                widx        = widx + PTR_ONE;
            end
            if (en && reg_ok) begin
                mem_d[widx] = '{typ: T_REG, addr: {27'd0, reg_waddr}, data: reg_wdata};
                widx        = widx + PTR_ONE;
            end
            wr_cnt = need;
            drop_d = '0;
        end else begin
            // k never exceeds 3, so one carry bit detects saturation.
            drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        wr_ptr_d = widx;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        level_d  = level_q + wr_cnt - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        out_valid  = (level_q != '0);
        out_type   = head.typ;
        out_addr   = head.addr;
        out_data   = head.data;
        fifo_level = level_q;
        drop_count = drop_q;
    end

endmodule

// File: tb/tb_mips_trace_encoder.sv
// Directed bench for mips_trace_encoder with a scoreboard of expected
// records filled from a behavioural model and drained on each handshake.
module tb_mips_trace_encoder;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [10:0] dec_pc;
    logic [31:0] dec_instr;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_type;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [4:0]  fifo_level;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [65:0] sb[$];
    int          m_level;
    int          m_drop;

    mips_trace_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .dec_pc(dec_pc), .dec_instr(dec_instr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_addr(out_addr), .out_data(out_data),
        .fifo_level(fifo_level), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] obs,
                         input logic [65:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural model of the record stream, evaluated on each clock edge.
    always @(posedge clk) begin
        int  k, need, free, wr;
        bit  rok, pop;
        if (!rst_n) begin
            sb.delete();
            m_level = 0;
            m_drop  = 0;
        end else begin
            rok  = reg_we && (reg_waddr != 5'd0);
            k    = en ? (1 + int'(mem_we) + int'(rok)) : 0;
            need = k + ((m_drop != 0) ? 1 : 0);
            free = DEPTH - m_level;
            pop  = (m_level != 0) && out_ready;
            wr   = 0;
            if (need > 0 && free >= need) begin
                if (m_drop != 0) sb.push_back({2'd3, 32'd0, 32'(m_drop)});
                if (en) sb.push_back({2'd0, 21'd0, dec_pc, dec_instr});
                if (en && mem_we) sb.push_back({2'd1, mem_addr, mem_wdata});
                if (en && rok) sb.push_back({2'd2, 27'd0, reg_waddr, reg_wdata});
                m_drop = 0;
                wr     = need;
            end else begin
                m_drop = m_drop + k;
                if (m_drop > 65535) m_drop = 65535;
            end
            m_level = m_level + wr - (pop ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("level", 66'(fifo_level), 66'(m_level));
            check("valid", 66'(out_valid), 66'(m_level != 0));
            check("drops", 66'(drop_count), 66'(m_drop));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 66'(sb.size()), 66'(1));
                end else begin
                    check("record", {out_type, out_addr, out_data}, sb.pop_front());
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [10:0] pc,
                         input logic [31:0] ins, input logic mw,
                         input logic [31:0] ma, input logic [31:0] md,
                         input logic rw, input logic [4:0] ra,
                         input logic [31:0] rd);
        en = e; dec_pc = pc; dec_instr = ins;
        mem_we = mw; mem_addr = ma; mem_wdata = md;
        reg_we = rw; reg_waddr = ra; reg_wdata = rd;
    endtask

    task automatic idle;
        drive(1'b0, 11'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic k3(input int i);
        drive(1'b1, 11'(i * 4), 32'(32'h1000_0000 + i), 1'b1,
              32'(32'h200 + i * 4), 32'(32'hAA00 + i), 1'b1,
              5'(1 + i % 31), 32'(32'h5500 + i));
    endtask

    task automatic wait_level_le(input int lim, input int budget,
                                 input string tag);
        int n = 0;
        while (m_level > lim && n < budget) begin
            tick;
            n++;
        end
        check(tag, 66'(m_level <= lim), 66'(1));
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b0;
        idle;
        repeat (2) tick;
        check("rst_level", 66'(fifo_level), 66'(0));
        check("rst_valid", 66'(out_valid), 66'(0));
        check("rst_drop", 66'(drop_count), 66'(0));
        check("rst_head", {out_type, out_addr, out_data}, 66'(0));
        rst_n = 1'b1;

        out_ready = 1'b1;
        drive(1'b1, 11'd4, 32'h2008_000A, 1'b0, 32'd0, 32'd0,
              1'b1, 5'd8, 32'h0000_000A);
        tick;
        idle;
        check("t1_level", 66'(fifo_level), 66'(2));
        check("t1_dec", {out_type, out_addr, out_data},
              {2'd0, 32'd4, 32'h2008_000A});
        tick;
        check("t1_reg", {out_type, out_addr, out_data},
              {2'd2, 32'd8, 32'h0000_000A});
        tick;
        check("t1_empty", 66'(out_valid), 66'(0));

        drive(1'b1, 11'd8, 32'h0000_0000, 1'b1, 32'h10, 32'hFF,
              1'b1, 5'd0, 32'h1234);
        tick;
        idle;
        check("t2_level", 66'(fifo_level), 66'(2));
        tick;
        check("t2_mem", {out_type, out_addr, out_data},
              {2'd1, 32'h10, 32'hFF});
        tick;
        check("t2_noreg", 66'(out_valid), 66'(0));

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            k3(i);
            tick;
        end
        check("t3_level15", 66'(fifo_level), 66'(15));
        check("t3_nodrop", 66'(drop_count), 66'(0));
        k3(5);
        tick;
        check("t3_level_hold", 66'(fifo_level), 66'(15));
        check("t3_drop3", 66'(drop_count), 66'(3));

        idle;
        out_ready = 1'b1;
        wait_level_le(12, 40, "t4_drain");
        k3(6);
        tick;
        idle;
        check("t4_drop0", 66'(drop_count), 66'(0));
        wait_level_le(0, 40, "t4_empty");

        begin
            int i = 0;
            out_ready = 1'b0;
            while (m_drop < 32'hFFFC && i < 30000) begin
                k3(i);
                tick;
                i++;
            end
            check("t5_reach", 66'(m_drop), 66'(32'hFFFC));
        end
        drive(1'b1, 11'd1, 32'h1, 1'b1, 32'h40, 32'h2, 1'b0, 5'd0, 32'd0);
        tick;
        check("t5_fffe", 66'(drop_count), 66'(16'hFFFE));
        k3(1);
        tick;
        k3(2);
        tick;
        idle;
        check("t5_sat", 66'(drop_count), 66'(16'hFFFF));
        check("t5_level", 66'(fifo_level), 66'(15));

        out_ready = 1'b1;
        wait_level_le(7, 40, "t6_drain");
        check("t6_level7", 66'(fifo_level), 66'(7));
        rst_n = 1'b0;
        k3(9);
        tick;
        check("t6_level0", 66'(fifo_level), 66'(0));
        check("t6_valid0", 66'(out_valid), 66'(0));
        check("t6_drop0", 66'(drop_count), 66'(0));
        check("t6_head0", {out_type, out_addr, out_data}, 66'(0));
        rst_n = 1'b1;
        idle;
        tick;
        check("t6_after", 66'(fifo_level), 66'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
